// File: rtl/rv32i_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rv32i_pipe_ctrl
//  Purpose  : N-stage pipeline sequencer: stall/flush vectors, per-stage valid
//             bits, branch-redirect hold across imem waits, perf counters.
//  Revision : 1.0 - initial release
// ============================================================================
module rv32i_pipe_ctrl #(
    parameter int NB_STAGES  = 5,
    parameter int HAZ_STAGE  = 1,
    parameter int EXEC_STAGE = 2,
    parameter int MEM_STAGE  = 3,
    parameter int CNT_W      = 32
) (
    input  logic                 clk_i,
    input  logic                 resetn_i,
    input  logic                 imem_valid_i,
    input  logic                 hazard_stall_i,
    input  logic                 branch_taken_i,
    input  logic                 dmem_req_i,
    input  logic                 dmem_valid_i,
    output logic [NB_STAGES-1:0] stall_o,
    output logic [NB_STAGES-1:0] flush_o,
    output logic [NB_STAGES-1:0] valid_o,
    output logic                 redirect_pending_o,
    output logic [CNT_W-1:0]     cycle_cnt_o,
    output logic [CNT_W-1:0]     instret_cnt_o,
    output logic [CNT_W-1:0]     fstall_cnt_o
);

    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    logic [NB_STAGES-1:1] r_valid_q;
    logic [NB_STAGES-1:1] w_valid_d;
    logic                 r_pend_q;
    logic                 w_pend_d;
    logic [CNT_W-1:0]     r_cycle_q, r_instret_q, r_fstall_q;
    logic [CNT_W-1:0]     w_cycle_d, w_instret_d, w_fstall_d;

    logic [NB_STAGES-1:0] w_valid;
    logic [NB_STAGES-1:0] w_stall;
    logic [NB_STAGES-1:0] w_flush;
    logic                 w_s_f, w_s_h, w_s_m, w_fl;

    // Fetch stage always holds a (possibly stalled) word, so its valid is tied.
    assign w_valid = {r_valid_q, 1'b1};

    assign w_s_f = ~imem_valid_i;
    assign w_s_h = hazard_stall_i & w_valid[HAZ_STAGE];
    assign w_s_m = dmem_req_i & w_valid[MEM_STAGE] & ~dmem_valid_i;

    // Sources are nested by stage, so the stall mask is a prefix up to the
    // highest active source.
    always_comb begin
        w_stall = '0;
        for (int j = 0; j < NB_STAGES; j++) begin
            w_stall[j] = (w_s_m && (j <= MEM_STAGE)) ||
                         (w_s_h && (j <= HAZ_STAGE)) ||
                         (w_s_f && (j == 0));
        end
    end

    assign w_fl = branch_taken_i & w_valid[EXEC_STAGE] & ~w_stall[EXEC_STAGE];

    always_comb begin
        w_flush = '0;
        for (int j = 1; j <= EXEC_STAGE; j++) begin
            w_flush[j] = w_fl;
        end
        // Wrong-path words keep arriving until the redirected fetch returns.
        w_flush[1] = w_flush[1] | r_pend_q;
    end

    always_comb begin
        w_valid_d = r_valid_q;
        for (int j = 1; j < NB_STAGES; j++) begin
            if (w_stall[j]) begin
                w_valid_d[j] = w_flush[j] ? 1'b0 : r_valid_q[j];
            end else if (w_flush[j] || w_stall[j-1]) begin
                w_valid_d[j] = 1'b0;
            end else begin
                w_valid_d[j] = w_valid[j-1];
            end
        end
    end

    always_comb begin
        w_pend_d    = (w_fl & ~imem_valid_i) | (r_pend_q & (~imem_valid_i | w_fl));
        w_cycle_d   = r_cycle_q + c_one;
        w_instret_d = w_valid[NB_STAGES-1] ? r_instret_q + c_one : r_instret_q;
        w_fstall_d  = w_s_f ? r_fstall_q + c_one : r_fstall_q;
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_valid_q   <= '0;
            r_pend_q    <= 1'b0;
            r_cycle_q   <= '0;
            r_instret_q <= '0;
            r_fstall_q  <= '0;
        end else begin
            r_valid_q   <= w_valid_d;
            r_pend_q    <= w_pend_d;
            r_cycle_q   <= w_cycle_d;
            r_instret_q <= w_instret_d;
            r_fstall_q  <= w_fstall_d;
        end
    end

    assign stall_o            = w_stall;
    assign flush_o            = w_flush;
    assign valid_o            = w_valid;
    assign redirect_pending_o = r_pend_q;
    assign cycle_cnt_o        = r_cycle_q;
    assign instret_cnt_o      = r_instret_q;
    assign fstall_cnt_o       = r_fstall_q;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rv32i_pipe_ctrl
//  Purpose  : Directed self-checking bench for rv32i_pipe_ctrl (default params).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rv32i_pipe_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        imem_valid = 1'b1;
    logic        hazard_stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic        dmem_req = 1'b0;
    logic        dmem_valid = 1'b0;
    logic [4:0]  stall_o, flush_o, valid_o;
    logic        redirect_pending;
    logic [31:0] cycle_cnt, instret_cnt, fstall_cnt;

    int checks = 0;
    int failures = 0;
    int n_ticks = 0;

    rv32i_pipe_ctrl dut (
        .clk_i              (clk),
        .resetn_i           (resetn),
        .imem_valid_i       (imem_valid),
        .hazard_stall_i     (hazard_stall),
        .branch_taken_i     (branch_taken),
        .dmem_req_i         (dmem_req),
        .dmem_valid_i       (dmem_valid),
        .stall_o            (stall_o),
        .flush_o            (flush_o),
        .valid_o            (valid_o),
        .redirect_pending_o (redirect_pending),
        .cycle_cnt_o        (cycle_cnt),
        .instret_cnt_o      (instret_cnt),
        .fstall_cnt_o       (fstall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
        n_ticks++;
    endtask

    task automatic test_reset;
        logic [4:0] exp_fill [4];
        exp_fill = '{5'b00011, 5'b00111, 5'b01111, 5'b11111};
        repeat (2) @(posedge clk);
        #1;
        checks++; if (valid_o !== 5'b00001) begin failures++; $display("FAIL rst_valid got=%b exp=00001", valid_o); end
        checks++; if (cycle_cnt !== 32'd0) begin failures++; $display("FAIL rst_cycle got=%0d exp=0", cycle_cnt); end
        checks++; if (stall_o !== 5'b00000) begin failures++; $display("FAIL rst_stall got=%b exp=00000", stall_o); end
        checks++; if (redirect_pending !== 1'b0) begin failures++; $display("FAIL rst_pend got=%b exp=0", redirect_pending); end
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (valid_o !== exp_fill[i]) begin failures++; $display("FAIL fill_valid%0d got=%b exp=%b", i, valid_o, exp_fill[i]); end
            checks++; if (stall_o !== 5'b00000) begin failures++; $display("FAIL fill_stall%0d got=%b exp=00000", i, stall_o); end
            checks++; if (instret_cnt !== 32'd0) begin failures++; $display("FAIL fill_instret%0d got=%0d exp=0", i, instret_cnt); end
        end
        tick();
        checks++; if (instret_cnt !== 32'd1) begin failures++; $display("FAIL first_instret got=%0d exp=1", instret_cnt); end
        checks++; if (cycle_cnt !== 32'd5) begin failures++; $display("FAIL fill_cycle got=%0d exp=5", cycle_cnt); end
    endtask

    task automatic test_fetch_stall;
        logic [4:0] exp_v [3];
        exp_v = '{5'b11101, 5'b11001, 5'b10001};
        imem_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (stall_o !== 5'b00001) begin failures++; $display("FAIL fstall_stall%0d got=%b exp=00001", i, stall_o); end
            tick();
            checks++; if (valid_o !== exp_v[i]) begin failures++; $display("FAIL fstall_valid%0d got=%b exp=%b", i, valid_o, exp_v[i]); end
        end
        checks++; if (fstall_cnt !== 32'd3) begin failures++; $display("FAIL fstall_cnt got=%0d exp=3", fstall_cnt); end
        imem_valid = 1'b1;
        tick();
        checks++; if (valid_o !== 5'b00011) begin failures++; $display("FAIL fstall_resume got=%b exp=00011", valid_o); end
        repeat (3) tick();
        checks++; if (instret_cnt !== 32'd5) begin failures++; $display("FAIL fstall_instret got=%0d exp=5", instret_cnt); end
        checks++; if (valid_o !== 5'b11111) begin failures++; $display("FAIL fstall_refill got=%b exp=11111", valid_o); end
    endtask

    task automatic test_mem_stall;
        dmem_req = 1'b1;
        dmem_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (stall_o !== 5'b01111) begin failures++; $display("FAIL mstall_stall%0d got=%b exp=01111", i, stall_o); end
            tick();
            checks++; if (valid_o !== 5'b01111) begin failures++; $display("FAIL mstall_valid%0d got=%b exp=01111", i, valid_o); end
        end
        dmem_valid = 1'b1;
        #1;
        checks++; if (stall_o !== 5'b00000) begin failures++; $display("FAIL mstall_release got=%b exp=00000", stall_o); end
        tick();
        dmem_req = 1'b0;
        dmem_valid = 1'b0;
        checks++; if (valid_o !== 5'b11111) begin failures++; $display("FAIL mstall_after got=%b exp=11111", valid_o); end
        checks++; if (instret_cnt !== 32'd6) begin failures++; $display("FAIL mstall_instret got=%0d exp=6", instret_cnt); end
    endtask

    task automatic test_branch;
        branch_taken = 1'b1;
        #1;
        checks++; if (flush_o !== 5'b00110) begin failures++; $display("FAIL br_flush got=%b exp=00110", flush_o); end
        tick();
        branch_taken = 1'b0;
        checks++; if (valid_o !== 5'b11001) begin failures++; $display("FAIL br_valid got=%b exp=11001", valid_o); end
        #1;
        checks++; if (flush_o !== 5'b00000) begin failures++; $display("FAIL br_flush_off got=%b exp=00000", flush_o); end
        repeat (5) tick();
        checks++; if (instret_cnt !== 32'd10) begin failures++; $display("FAIL br_instret got=%0d exp=10", instret_cnt); end
        checks++; if (valid_o !== 5'b11111) begin failures++; $display("FAIL br_refill got=%b exp=11111", valid_o); end
    endtask

    task automatic test_branch_mem_stall;
        dmem_req = 1'b1;
        dmem_valid = 1'b0;
        branch_taken = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (flush_o !== 5'b00000) begin failures++; $display("FAIL brm_flush_held%0d got=%b exp=00000", i, flush_o); end
            tick();
        end
        dmem_valid = 1'b1;
        #1;
        checks++; if (flush_o !== 5'b00110) begin failures++; $display("FAIL brm_flush got=%b exp=00110", flush_o); end
        tick();
        branch_taken = 1'b0;
        dmem_req = 1'b0;
        dmem_valid = 1'b0;
        #1;
        checks++; if (flush_o !== 5'b00000) begin failures++; $display("FAIL brm_flush_once got=%b exp=00000", flush_o); end
        checks++; if (valid_o !== 5'b11001) begin failures++; $display("FAIL brm_valid got=%b exp=11001", valid_o); end
        repeat (4) tick();
        checks++; if (instret_cnt !== 32'd13) begin failures++; $display("FAIL brm_instret got=%0d exp=13", instret_cnt); end
    endtask

    task automatic test_redirect;
        imem_valid = 1'b0;
        branch_taken = 1'b1;
        #1;
        checks++; if (flush_o !== 5'b00110) begin failures++; $display("FAIL rd_flush0 got=%b exp=00110", flush_o); end
        checks++; if (stall_o !== 5'b00001) begin failures++; $display("FAIL rd_stall0 got=%b exp=00001", stall_o); end
        tick();
        branch_taken = 1'b0;
        #1;
        checks++; if (redirect_pending !== 1'b1) begin failures++; $display("FAIL rd_pend1 got=%b exp=1", redirect_pending); end
        checks++; if (flush_o !== 5'b00010) begin failures++; $display("FAIL rd_flush1 got=%b exp=00010", flush_o); end
        tick();
        imem_valid = 1'b1;
        #1;
        checks++; if (redirect_pending !== 1'b1) begin failures++; $display("FAIL rd_pend2 got=%b exp=1", redirect_pending); end
        checks++; if (flush_o !== 5'b00010) begin failures++; $display("FAIL rd_flush2 got=%b exp=00010", flush_o); end
        checks++; if (valid_o !== 5'b10001) begin failures++; $display("FAIL rd_valid2 got=%b exp=10001", valid_o); end
        tick();
        checks++; if (redirect_pending !== 1'b0) begin failures++; $display("FAIL rd_clear got=%b exp=0", redirect_pending); end
        checks++; if (flush_o !== 5'b00000) begin failures++; $display("FAIL rd_flush3 got=%b exp=00000", flush_o); end
        checks++; if (valid_o !== 5'b00001) begin failures++; $display("FAIL rd_valid3 got=%b exp=00001", valid_o); end
        tick();
        checks++; if (valid_o !== 5'b00011) begin failures++; $display("FAIL rd_newword got=%b exp=00011", valid_o); end
        checks++; if (fstall_cnt !== 32'd5) begin failures++; $display("FAIL rd_fstall got=%0d exp=5", fstall_cnt); end
    endtask

    task automatic test_hazard;
        hazard_stall = 1'b1;
        #1;
        checks++; if (stall_o !== 5'b00011) begin failures++; $display("FAIL hz_stall got=%b exp=00011", stall_o); end
        tick();
        hazard_stall = 1'b0;
        checks++; if (valid_o !== 5'b00011) begin failures++; $display("FAIL hz_valid got=%b exp=00011", valid_o); end
        tick();
        checks++; if (valid_o !== 5'b00111) begin failures++; $display("FAIL hz_resume got=%b exp=00111", valid_o); end
        checks++; if (cycle_cnt !== 32'(n_ticks)) begin failures++; $display("FAIL cycle_cnt got=%0d exp=%0d", cycle_cnt, n_ticks); end
    endtask

    task automatic test_async_reset;
        #2;
        resetn = 1'b0;
        #1;
        checks++; if (cycle_cnt !== 32'd0) begin failures++; $display("FAIL ar_cycle got=%0d exp=0", cycle_cnt); end
        checks++; if (instret_cnt !== 32'd0) begin failures++; $display("FAIL ar_instret got=%0d exp=0", instret_cnt); end
        checks++; if (fstall_cnt !== 32'd0) begin failures++; $display("FAIL ar_fstall got=%0d exp=0", fstall_cnt); end
        checks++; if (valid_o !== 5'b00001) begin failures++; $display("FAIL ar_valid got=%b exp=00001", valid_o); end
        checks++; if (stall_o !== 5'b00000) begin failures++; $display("FAIL ar_stall got=%b exp=00000", stall_o); end
        imem_valid = 1'b0;
        #1;
        checks++; if (stall_o !== 5'b00001) begin failures++; $display("FAIL ar_fstall_comb got=%b exp=00001", stall_o); end
        imem_valid = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
        n_ticks = 0;
        tick();
        checks++; if (valid_o !== 5'b00011) begin failures++; $display("FAIL ar_restart got=%b exp=00011", valid_o); end
        checks++; if (cycle_cnt !== 32'd1) begin failures++; $display("FAIL ar_cycle1 got=%0d exp=1", cycle_cnt); end
    endtask

    initial begin
        test_reset();
        test_fetch_stall();
        test_mem_stall();
        test_branch();
        test_branch_mem_stall();
        test_redirect();
        test_hazard();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
